// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : fb_pkg                                                          |
// | Purpose  : Shared types and constants for the framebuffer scanout block.   |
// |            Scan state encoding and the fixed scanout pipeline latency.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fb_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,   // idle after reset until the first frame pulse
    WAIT_ROW   = 2'd1,   // frame started, waiting for the window's top line
    ROWS       = 2'd2,   // framebuffer rows are being scanned out
    DONE       = 2'd3    // all rows emitted, idle until next frame pulse
  } fb_scan_state_t;

  // Cycles from sx/sy to the aligned cidx/paint outputs.
  localparam int LAT_SCANOUT = 3;

endpackage
`default_nettype wire

// File: rtl/fb_scan_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_scan_axis                                                    |
// | Purpose  : Scale/repeat counter for one scan axis. Each enabled cycle      |
// |            bumps the repeat count; after 'scale' enabled cycles the main   |
// |            count advances (saturating at LIMIT) and the repeat wraps.      |
// | Ports    : clk_pix, rst_pix_n  clock, async active-low reset              |
// |            clr                 synchronous clear (wins over en)          |
// |            en                  count enable                              |
// |            scale               repeat factor, expected 1..2^SCALEW-1     |
// |            count               number of completed repeats (saturating)  |
// |            rep                 position inside the current repeat        |
// |            advance             count steps on this cycle                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fb_scan_axis #(
  parameter int CNTW   = 9,
  parameter int LIMIT  = 320,
  parameter int SCALEW = 6
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic              clr,
  input  logic              en,
  input  logic [SCALEW-1:0] scale,
  output logic [CNTW-1:0]   count,
  output logic [SCALEW-1:0] rep,
  output logic              advance
);

  logic last;

  assign last    = (rep == scale - SCALEW'(1));
  assign advance = en && !clr && last;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      count <= '0;
      rep   <= '0;
    end else if (clr) begin
      count <= '0;
      rep   <= '0;
    end else if (en) begin
      if (last) begin
        rep <= '0;
        if (count != CNTW'(LIMIT)) begin
          count <= count + CNTW'(1);
        end
      end else begin
        rep <= rep + SCALEW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_scanout                                                      |
// | Purpose  : Linebuffer-free framebuffer scanout. Turns display sx/sy into   |
// |            BRAM read addresses with runtime per-axis integer scale and a   |
// |            signed window offset, and returns a colour index plus paint     |
// |            flag aligned LAT_SCANOUT cycles after sx/sy.                    |
// | Ports    : clk_pix, rst_pix_n  pixel clock, async active-low reset        |
// |            sx, sy, de          signed display position, data enable      |
// |            frame, line         1-cycle frame / line start pulses         |
// |            offx, offy          window offset (sampled at frame)          |
// |            scale_x, scale_y    per-axis scale (sampled at frame, 0 -> 1)  |
// |            buf_sel             requested display buffer                  |
// |            fb_addr, fb_data    BRAM read port (1-cycle read latency)     |
// |            cidx, paint         aligned colour index and valid flag       |
// |            active              high while rows are being scanned         |
// | Config   : FB_SCANOUT_DBUF_EN  enables double buffering via buf_sel       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fb_scanout
  import fb_pkg::*;
#(
  parameter int CORDW     = 16,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int FB_DATAW  = 4,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT * 2),
  parameter int SCALEW    = 6
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic                    de,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] offx,
  input  logic signed [CORDW-1:0] offy,
  input  logic [SCALEW-1:0]       scale_x,
  input  logic [SCALEW-1:0]       scale_y,
  input  logic                    buf_sel,
  output logic [FB_ADDRW-1:0]     fb_addr,
  input  logic [FB_DATAW-1:0]     fb_data,
  output logic [FB_DATAW-1:0]     cidx,
  output logic                    paint,
  output logic                    active
);

  localparam int COLW = $clog2(FB_WIDTH + 1);
  localparam int ROWW = $clog2(FB_HEIGHT + 1);

  fb_scan_state_t          state, state_next;
  logic signed [CORDW-1:0] offx_s, offy_s;
  logic [SCALEW-1:0]       scale_x_s, scale_y_s;
  logic [FB_ADDRW-1:0]     buf_base, row_base;
  logic [COLW-1:0]         col;
  logic [ROWW-1:0]         row;
  logic [SCALEW-1:0]       rep_x_unused, rep_y_unused;
  logic                    x_adv_unused, y_adv;
  logic                    row_start, y_en, in_win;
  logic                    win_d1, win_d2, de_d1, de_d2;

  // Frame pulses outrank line pulses, so line-driven events are masked by frame.
  assign row_start = line && !frame && (state == WAIT_ROW) && (sy == offy_s);
  assign y_en      = line && !frame && (state == ROWS);
  // Pixels left of the display edge (negative offx) still count, clipping the
  // left side of the image rather than shifting it.
  assign in_win    = (state == ROWS) && (sx >= offx_s) && (col < COLW'(FB_WIDTH));

  // Shadow configuration: only changes on a frame pulse so a frame never tears.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      offx_s    <= '0;
      offy_s    <= '0;
      scale_x_s <= SCALEW'(1);
      scale_y_s <= SCALEW'(1);
    end else if (frame) begin
      offx_s    <= offx;
      offy_s    <= offy;
      scale_x_s <= (scale_x == '0) ? SCALEW'(1) : scale_x;
      scale_y_s <= (scale_y == '0) ? SCALEW'(1) : scale_y;
    end
  end

`ifdef FB_SCANOUT_DBUF_EN
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      buf_base <= '0;
    end else if (frame) begin
      buf_base <= buf_sel ? FB_ADDRW'(FB_WIDTH * FB_HEIGHT) : '0;
    end
  end
`else
  logic unused_buf_sel;
  assign unused_buf_sel = buf_sel;
  assign buf_base       = '0;
`endif

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state  <= WAIT_FRAME;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next == ROWS);
    end
  end

  always_comb begin
    state_next = state;
    if (frame) begin
      state_next = WAIT_ROW;
    end else begin
      case (state)
        WAIT_ROW: if (row_start) state_next = ROWS;
        ROWS:     if (y_adv && (row == ROWW'(FB_HEIGHT - 1))) state_next = DONE;
        default:  state_next = state;
      endcase
    end
  end

  // The last row never bumps row_base, keeping every address inside the buffer.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      row_base <= '0;
    end else if (row_start) begin
      row_base <= buf_base;
    end else if (y_adv && (row < ROWW'(FB_HEIGHT - 1))) begin
      row_base <= row_base + FB_ADDRW'(FB_WIDTH);
    end
  end

  fb_scan_axis #(
    .CNTW   (COLW),
    .LIMIT  (FB_WIDTH),
    .SCALEW (SCALEW)
  ) u_axis_x (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .clr       (line),
    .en        (in_win),
    .scale     (scale_x_s),
    .count     (col),
    .rep       (rep_x_unused),
    .advance   (x_adv_unused)
  );

  fb_scan_axis #(
    .CNTW   (ROWW),
    .LIMIT  (FB_HEIGHT),
    .SCALEW (SCALEW)
  ) u_axis_y (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .clr       (row_start),
    .en        (y_en),
    .scale     (scale_y_s),
    .count     (row),
    .rep       (rep_y_unused),
    .advance   (y_adv)
  );

  // S1 address, S2 BRAM read, S3 output register.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      fb_addr <= '0;
      win_d1  <= 1'b0;
      win_d2  <= 1'b0;
      de_d1   <= 1'b0;
      de_d2   <= 1'b0;
      paint   <= 1'b0;
      cidx    <= '0;
    end else begin
      if (in_win) begin
        fb_addr <= row_base + FB_ADDRW'(col);
      end
      win_d1 <= in_win;
      de_d1  <= de;
      win_d2 <= win_d1;
      de_d2  <= de_d1;
      paint  <= win_d2 && de_d2;
      cidx   <= (win_d2 && de_d2) ? fb_data : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fb_scanout                                                   |
// | Purpose  : Directed self-checking bench for fb_scanout. A BRAM model holds |
// |            addr%16 at every address. Outputs are captured per source sx    |
// |            (the sx presented LAT_SCANOUT cycles earlier); fb_addr is       |
// |            captured against the sx of the cycle that produced it.          |
// | Config   : FB_SCANOUT_DBUF_EN  selects expected buffer-swap behaviour      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fb_scanout;
  import fb_pkg::*;

  localparam int CORDW     = 16;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 180;
  localparam int FB_DATAW  = 4;
  localparam int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT * 2);
  localparam int SCALEW    = 6;
  localparam int XOFS      = 16;
  localparam int NCAP      = 1024;
`ifdef FB_SCANOUT_DBUF_EN
  localparam int BASE1     = FB_WIDTH * FB_HEIGHT;
`else
  localparam int BASE1     = 0;
`endif

  logic                    clk_pix = 1'b0;
  logic                    rst_pix_n = 1'b0;
  int                      cur_sx = 0;
  logic signed [CORDW-1:0] sx, sy = '0;
  logic                    de = 1'b0, frame = 1'b0, line = 1'b0, buf_sel = 1'b0;
  logic signed [CORDW-1:0] offx = '0, offy = '0;
  logic [SCALEW-1:0]       scale_x = 6'd1, scale_y = 6'd1;
  logic [FB_ADDRW-1:0]     fb_addr;
  logic [FB_DATAW-1:0]     fb_data, cidx;
  logic                    paint, active;

  int vectors = 0;
  int miscompares = 0;

  assign sx = CORDW'(cur_sx);

  always #5 clk_pix = ~clk_pix;

  fb_scanout #(
    .CORDW(CORDW), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT),
    .FB_DATAW(FB_DATAW), .FB_ADDRW(FB_ADDRW), .SCALEW(SCALEW)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
    .frame(frame), .line(line), .offx(offx), .offy(offy),
    .scale_x(scale_x), .scale_y(scale_y), .buf_sel(buf_sel),
    .fb_addr(fb_addr), .fb_data(fb_data), .cidx(cidx), .paint(paint),
    .active(active)
  );

  // BRAM model: content is addr%16, one cycle read latency.
  always @(posedge clk_pix) fb_data <= FB_DATAW'(fb_addr % 16);

  // Capture outputs indexed by the sx that produced them.
  int d_sx [1:LAT_SCANOUT];
  logic                cap_paint [0:NCAP-1];
  logic [FB_DATAW-1:0] cap_cidx  [0:NCAP-1];
  logic [FB_ADDRW-1:0] cap_addr  [0:NCAP-1];

  always @(posedge clk_pix) begin
    d_sx[1] <= cur_sx;
    for (int i = 2; i <= LAT_SCANOUT; i++) d_sx[i] <= d_sx[i-1];
  end

  always @(negedge clk_pix) begin
    if (d_sx[LAT_SCANOUT] >= -XOFS && d_sx[LAT_SCANOUT] < NCAP - XOFS) begin
      cap_paint[d_sx[LAT_SCANOUT] + XOFS] = paint;
      cap_cidx[d_sx[LAT_SCANOUT] + XOFS]  = cidx;
    end
    if (d_sx[1] >= -XOFS && d_sx[1] < NCAP - XOFS)
      cap_addr[d_sx[1] + XOFS] = fb_addr;
  end

  function automatic int ix(input int x);
    return x + XOFS;
  endfunction

  task automatic cfg(input int ox, input int oy, input int scx, input int scy);
    offx    = CORDW'(ox);
    offy    = CORDW'(oy);
    scale_x = SCALEW'(scx);
    scale_y = SCALEW'(scy);
  endtask

  // One display line: line pulse at sx=-8, then sx up to x1, plus 3 trailing
  // cycles so outputs for sx<=x1 are captured before returning.
  task automatic do_line(input int y, input int x1, input bit frm);
    for (int x = -8; x <= x1 + 3; x++) begin
      cur_sx = x;
      sy     = CORDW'(y);
      de     = (x >= 0 && x < 640 && y >= 0 && y < 480);
      line   = (x == -8);
      frame  = frm && (x == -8);
      @(posedge clk_pix); #1;
    end
    line  = 1'b0;
    frame = 1'b0;
    de    = 1'b0;
  endtask

  task automatic short_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) do_line(y, 7, 1'b0);
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    vectors++; if (fb_addr !== '0) begin miscompares++; $display("FAIL rst_fb_addr: got %0d expected 0", fb_addr); end
    vectors++; if (cidx !== '0)    begin miscompares++; $display("FAIL rst_cidx: got %0d expected 0", cidx); end
    vectors++; if (paint !== 1'b0) begin miscompares++; $display("FAIL rst_paint: got %b expected 0", paint); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL rst_active: got %b expected 0", active); end
    rst_pix_n = 1'b1;
    @(posedge clk_pix); #1;
  endtask

  task automatic test_scale2();
    logic [7:0] pb;
    cfg(0, 60, 2, 2);
    do_line(-2, 7, 1'b1);
    short_lines(-1, 59);
    vectors++; if (cap_paint[ix(0)] !== 1'b0) begin miscompares++; $display("FAIL s2_paint_y59: got %b expected 0", cap_paint[ix(0)]); end
    do_line(60, 640, 1'b0);
    vectors++; if (cap_paint[ix(0)] !== 1'b1)   begin miscompares++; $display("FAIL s2_paint_y60_x0: got %b expected 1", cap_paint[ix(0)]); end
    vectors++; if (cap_paint[ix(639)] !== 1'b1) begin miscompares++; $display("FAIL s2_paint_y60_x639: got %b expected 1", cap_paint[ix(639)]); end
    vectors++; if (cap_paint[ix(640)] !== 1'b0) begin miscompares++; $display("FAIL s2_paint_y60_x640: got %b expected 0", cap_paint[ix(640)]); end
    vectors++; if (cap_cidx[ix(0)] !== 4'd0) begin miscompares++; $display("FAIL s2_cidx_x0: got %0d expected 0", cap_cidx[ix(0)]); end
    vectors++; if (cap_cidx[ix(1)] !== 4'd0) begin miscompares++; $display("FAIL s2_cidx_x1: got %0d expected 0", cap_cidx[ix(1)]); end
    vectors++; if (cap_cidx[ix(2)] !== 4'd1) begin miscompares++; $display("FAIL s2_cidx_x2: got %0d expected 1", cap_cidx[ix(2)]); end
    do_line(61, 640, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd0) begin miscompares++; $display("FAIL s2_addr_y61: got %0d expected 0", cap_addr[ix(0)]); end
    vectors++; if (cap_cidx[ix(2)] !== 4'd1)  begin miscompares++; $display("FAIL s2_cidx_y61_x2: got %0d expected 1", cap_cidx[ix(2)]); end
    do_line(62, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL s2_addr_y62: got %0d expected 320", cap_addr[ix(0)]); end
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL s2_active_rows: got %b expected 1", active); end
    for (int y = 63; y <= 418; y++) begin
      do_line(y, 7, 1'b0);
      for (int x = 0; x < 8; x++) pb[x] = cap_paint[ix(x)];
      vectors++; if (pb !== 8'hFF) begin miscompares++; $display("FAIL s2_paint_row y=%0d: got %b expected 11111111", y, pb); end
    end
    do_line(419, 640, 1'b0);
    vectors++; if (cap_paint[ix(639)] !== 1'b1)    begin miscompares++; $display("FAIL s2_paint_y419: got %b expected 1", cap_paint[ix(639)]); end
    vectors++; if (cap_addr[ix(639)] !== 17'd57599) begin miscompares++; $display("FAIL s2_addr_last: got %0d expected 57599", cap_addr[ix(639)]); end
    vectors++; if (cap_cidx[ix(639)] !== 4'd15)    begin miscompares++; $display("FAIL s2_cidx_last: got %0d expected 15", cap_cidx[ix(639)]); end
    do_line(420, 7, 1'b0);
    vectors++; if (cap_paint[ix(0)] !== 1'b0) begin miscompares++; $display("FAIL s2_paint_y420: got %b expected 0", cap_paint[ix(0)]); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL s2_active_done: got %b expected 0", active); end
  endtask

  task automatic test_scale_x3();
    cfg(10, 0, 3, 1);
    do_line(-2, 7, 1'b1);
    do_line(-1, 7, 1'b0);
    do_line(0, 1000, 1'b0);
    vectors++; if (cap_paint[ix(9)] !== 1'b0)  begin miscompares++; $display("FAIL x3_paint_x9: got %b expected 0", cap_paint[ix(9)]); end
    vectors++; if (cap_paint[ix(10)] !== 1'b1) begin miscompares++; $display("FAIL x3_paint_x10: got %b expected 1", cap_paint[ix(10)]); end
    vectors++; if (cap_addr[ix(12)] !== 17'd0) begin miscompares++; $display("FAIL x3_addr_x12: got %0d expected 0", cap_addr[ix(12)]); end
    vectors++; if (cap_addr[ix(13)] !== 17'd1) begin miscompares++; $display("FAIL x3_addr_x13: got %0d expected 1", cap_addr[ix(13)]); end
    vectors++; if (cap_cidx[ix(16)] !== 4'd2)  begin miscompares++; $display("FAIL x3_cidx_x16: got %0d expected 2", cap_cidx[ix(16)]); end
    vectors++; if (cap_addr[ix(966)] !== 17'd318) begin miscompares++; $display("FAIL x3_addr_x966: got %0d expected 318", cap_addr[ix(966)]); end
    vectors++; if (cap_addr[ix(967)] !== 17'd319) begin miscompares++; $display("FAIL x3_addr_x967: got %0d expected 319", cap_addr[ix(967)]); end
    vectors++; if (cap_addr[ix(1000)] !== 17'd319) begin miscompares++; $display("FAIL x3_addr_hold: got %0d expected 319", cap_addr[ix(1000)]); end
    vectors++; if (cap_paint[ix(640)] !== 1'b0) begin miscompares++; $display("FAIL x3_paint_x640: got %b expected 0", cap_paint[ix(640)]); end
  endtask

  task automatic test_neg_offx();
    cfg(-4, 0, 1, 1);
    do_line(-2, 7, 1'b1);
    do_line(-1, 7, 1'b0);
    do_line(0, 7, 1'b0);
    vectors++; if (cap_addr[ix(-4)] !== 17'd0) begin miscompares++; $display("FAIL nx_addr_xm4: got %0d expected 0", cap_addr[ix(-4)]); end
    vectors++; if (cap_paint[ix(-1)] !== 1'b0) begin miscompares++; $display("FAIL nx_paint_xm1: got %b expected 0", cap_paint[ix(-1)]); end
    vectors++; if (cap_paint[ix(0)] !== 1'b1)  begin miscompares++; $display("FAIL nx_paint_x0: got %b expected 1", cap_paint[ix(0)]); end
    vectors++; if (cap_cidx[ix(0)] !== 4'd4)   begin miscompares++; $display("FAIL nx_cidx_x0: got %0d expected 4", cap_cidx[ix(0)]); end
    vectors++; if (cap_cidx[ix(5)] !== 4'd9)   begin miscompares++; $display("FAIL nx_cidx_x5: got %0d expected 9", cap_cidx[ix(5)]); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]          pb;
    logic [FB_ADDRW-1:0] ab;
    cfg(0, 60, 2, 2);
    do_line(-2, 7, 1'b1);
    short_lines(-1, 99);
    rst_pix_n = 1'b0;
    #1;
    vectors++; if (paint !== 1'b0 || fb_addr !== '0) begin miscompares++; $display("FAIL mr_async: got paint=%b addr=%0d expected 0/0", paint, fb_addr); end
    short_lines(100, 199);
    rst_pix_n = 1'b1;
    for (int y = 200; y <= 479; y++) begin
      do_line(y, 7, 1'b0);
      ab = '0;
      for (int x = 0; x < 8; x++) begin
        pb[x] = cap_paint[ix(x)];
        ab    = ab | cap_addr[ix(x)];
      end
      vectors++; if (pb !== 8'h00 || ab !== '0 || active !== 1'b0) begin
        miscompares++; $display("FAIL mr_idle y=%0d: got paint=%b addr_or=%0d active=%b expected 0", y, pb, ab, active);
      end
    end
    do_line(-2, 7, 1'b1);
    short_lines(-1, 59);
    do_line(60, 7, 1'b0);
    vectors++; if (cap_paint[ix(0)] !== 1'b1) begin miscompares++; $display("FAIL mr_paint_y60: got %b expected 1", cap_paint[ix(0)]); end
    vectors++; if (cap_cidx[ix(2)] !== 4'd1)  begin miscompares++; $display("FAIL mr_cidx_y60: got %0d expected 1", cap_cidx[ix(2)]); end
    do_line(61, 7, 1'b0);
    do_line(62, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL mr_addr_y62: got %0d expected 320", cap_addr[ix(0)]); end
  endtask

  task automatic test_scale_change();
    cfg(0, 60, 2, 2);
    do_line(-2, 7, 1'b1);
    short_lines(-1, 61);
    scale_y = 6'd1;
    do_line(62, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL sc_addr_y62: got %0d expected 320", cap_addr[ix(0)]); end
    do_line(63, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL sc_addr_y63: got %0d expected 320", cap_addr[ix(0)]); end
    do_line(64, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd640) begin miscompares++; $display("FAIL sc_addr_y64: got %0d expected 640", cap_addr[ix(0)]); end
    do_line(-2, 7, 1'b1);
    short_lines(-1, 60);
    vectors++; if (cap_addr[ix(0)] !== 17'd0) begin miscompares++; $display("FAIL sc_addr_n60: got %0d expected 0", cap_addr[ix(0)]); end
    do_line(61, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL sc_addr_n61: got %0d expected 320", cap_addr[ix(0)]); end
  endtask

  task automatic test_dbuf();
    cfg(0, 0, 1, 1);
    buf_sel = 1'b0;
    do_line(-2, 7, 1'b1);
    do_line(-1, 7, 1'b0);
    do_line(0, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd0) begin miscompares++; $display("FAIL db_addr_b0_y0: got %0d expected 0", cap_addr[ix(0)]); end
    buf_sel = 1'b1;
    do_line(1, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL db_addr_midswap: got %0d expected 320", cap_addr[ix(0)]); end
    do_line(-2, 7, 1'b1);
    do_line(-1, 7, 1'b0);
    do_line(0, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'(BASE1)) begin miscompares++; $display("FAIL db_addr_b1_y0: got %0d expected %0d", cap_addr[ix(0)], BASE1); end
    do_line(1, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'(BASE1 + 320)) begin miscompares++; $display("FAIL db_addr_b1_y1: got %0d expected %0d", cap_addr[ix(0)], BASE1 + 320); end
    buf_sel = 1'b0;
  endtask

  task automatic test_frame_line();
    cfg(0, 0, 1, 1);
    do_line(-2, 7, 1'b1);
    short_lines(-1, 9);
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL fl_active_before: got %b expected 1", active); end
    // frame and line together on the window's top line: frame must win
    do_line(0, 7, 1'b1);
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL fl_active_after: got %b expected 0", active); end
    vectors++; if (cap_paint[ix(0)] !== 1'b0) begin miscompares++; $display("FAIL fl_paint_inject: got %b expected 0", cap_paint[ix(0)]); end
    do_line(1, 7, 1'b0);
    vectors++; if (cap_paint[ix(0)] !== 1'b0) begin miscompares++; $display("FAIL fl_paint_wait: got %b expected 0", cap_paint[ix(0)]); end
    do_line(0, 7, 1'b0);
    vectors++; if (cap_paint[ix(0)] !== 1'b1 || cap_addr[ix(0)] !== 17'd0) begin
      miscompares++; $display("FAIL fl_restart: got paint=%b addr=%0d expected 1/0", cap_paint[ix(0)], cap_addr[ix(0)]);
    end
    do_line(1, 7, 1'b0);
    vectors++; if (cap_addr[ix(0)] !== 17'd320) begin miscompares++; $display("FAIL fl_row1: got %0d expected 320", cap_addr[ix(0)]); end
  endtask

  initial begin
    test_reset();
    test_scale2();
    test_scale_x3();
    test_neg_offx();
    test_reset_midframe();
    test_scale_change();
    test_dbuf();
    test_frame_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
